// File: rtl/ddfs_phase_acc.sv
// DDFS phase accumulator with a valid/ready FCW update path and quarter-wave
// address folding; feeds the sine LUT with a registered address, sign and strobe.
module ddfs_phase_acc #(
  parameter int NBIT_ACC    = 16,
  parameter int NBIT_LUT    = 6,
  parameter int UPDATE_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sync_clr,
  input  logic [NBIT_ACC-1:0] fcw_in,
  input  logic                fcw_valid,
  output logic                fcw_ready,
  output logic [NBIT_LUT-1:0] lut_addr,
  output logic                neg,
  output logic                out_valid,
  output logic                wrap
);

  typedef enum logic [0:0] {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t              state_r;
  logic [NBIT_ACC-1:0] acc_r;
  logic [NBIT_ACC-1:0] fcw_act_r;
  logic [NBIT_ACC-1:0] fcw_pend_r;
  logic                carry_r;
  logic                en_q_r;
  logic [NBIT_ACC:0]   sum_s;
  logic                apply_s;
  logic [NBIT_LUT+1:0] phase_s;

  // Odd quadrants walk the quarter-wave table backwards.
  function automatic logic [NBIT_LUT-1:0] fold_addr(input logic [NBIT_LUT+1:0] p);
    logic [NBIT_LUT-1:0] raw;
    raw = p[NBIT_LUT-1:0];
    if (p[NBIT_LUT]) begin
      fold_addr = ~raw;
    end else begin
      fold_addr = raw;
    end
  endfunction

  assign phase_s   = acc_r[NBIT_ACC-1 -: NBIT_LUT+2];
  assign fcw_ready = (state_r == IDLE) && !rst;

  // Next accumulator sum and the decision to commit a pending word this edge.
  always_comb begin
    sum_s   = {1'b0, acc_r} + {1'b0, fcw_act_r};
    apply_s = 1'b0;
    if (state_r == PENDING) begin
      if (UPDATE_MODE == 0) begin
        apply_s = en | sync_clr;
      end else begin
        apply_s = sync_clr | (en & sum_s[NBIT_ACC]);
      end
    end else begin
      apply_s = 1'b0;
    end
  end

  // FCW handshake: capture one word, hold it until it is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      fcw_pend_r <= {NBIT_ACC{1'b0}};
      fcw_act_r  <= {NBIT_ACC{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (fcw_valid) begin
            fcw_pend_r <= fcw_in;
            state_r    <= PENDING;
          end
        end
        PENDING: begin
          if (apply_s) begin
            fcw_act_r <= fcw_pend_r;
            state_r   <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Phase accumulator; clear wins over accumulate, the apply edge still uses the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r   <= {NBIT_ACC{1'b0}};
      carry_r <= 1'b0;
    end else if (sync_clr) begin
      acc_r   <= {NBIT_ACC{1'b0}};
      carry_r <= 1'b0;
    end else if (en) begin
      acc_r   <= sum_s[NBIT_ACC-1:0];
      carry_r <= sum_s[NBIT_ACC];
    end else begin
      acc_r   <= acc_r;
      carry_r <= carry_r;
    end
  end

  // Output register stage, one edge behind the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q_r    <= 1'b0;
      lut_addr  <= {NBIT_LUT{1'b0}};
      neg       <= 1'b0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      en_q_r    <= en | sync_clr;
      lut_addr  <= fold_addr(phase_s);
      neg       <= phase_s[NBIT_LUT+1];
      out_valid <= en_q_r;
      wrap      <= carry_r & en_q_r;
    end
  end

endmodule
